// File: rtl/adc_scan_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_scheduler_if
//  Description : Start/busy/done handshake between the scan scheduler and the
//                16-bit AD7908 SPI frame engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_scan_scheduler_if;
    logic        conv_start;   // one-cycle frame start
    logic [15:0] conv_ctrl;    // control word shifted out during the frame
    logic        conv_busy;    // engine busy
    logic        conv_done;    // one-cycle frame complete
    logic [15:0] conv_rx;      // received word, valid with conv_done

    // Scheduler side
    modport master (
        output conv_start,
        output conv_ctrl,
        input  conv_busy,
        input  conv_done,
        input  conv_rx
    );

    // Frame engine side
    modport slave (
        input  conv_start,
        input  conv_ctrl,
        output conv_busy,
        output conv_done,
        output conv_rx
    );
endinterface
`default_nettype wire

// File: rtl/adc_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_scheduler
//  Description : Schedules AD7908 conversion frames. Round-robins over enabled
//                channels on a periodic tick, gives one-shot host requests
//                priority, and re-aligns the ADC's one-frame result pipeline
//                so every result is tagged with the channel it belongs to.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_scheduler #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [7:0]        chan_en,
    input  wire logic              host_req,
    input  wire logic [2:0]        host_ch,
    output logic                   host_busy,
    output logic                   host_ack,
    output logic [7:0]             host_data,
    adc_scan_scheduler_if.master   eng,
    output logic                   result_valid,
    output logic [2:0]             result_ch,
    output logic [7:0]             result_data,
    output logic [63:0]            ch_values
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic        OWNER_SCAN  = 1'b0;
    localparam logic        OWNER_HOST  = 1'b1;
    localparam logic [15:0] C_TICK_LAST = 16'(SCAN_DIV - 1);

    // WRITE=1, SEQ=0, ADD, PM=11 (normal), SHADOW=0, RANGE=1, CODING=1
    function automatic logic [15:0] ctrl_word(input logic [2:0] ch);
        return {1'b1, 1'b0, 1'b1, ch, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,        state_d;
    logic [15:0] tick_cnt_q,     tick_cnt_d;
    logic        scan_due_q,     scan_due_d;
    logic        host_busy_q,    host_busy_d;
    logic [2:0]  host_ch_q,      host_ch_d;
    logic        host_issued_q,  host_issued_d;
    logic [2:0]  last_scan_ch_q, last_scan_ch_d;
    logic        pending_vld_q,  pending_vld_d;
    logic [2:0]  pending_ch_q,   pending_ch_d;
    logic        pending_owner_q, pending_owner_d;
    logic [2:0]  issued_ch_q,    issued_ch_d;
    logic        issued_owner_q, issued_owner_d;
    logic        conv_start_q,   conv_start_d;
    logic [15:0] conv_ctrl_q,    conv_ctrl_d;
    logic        result_valid_q, result_valid_d;
    logic [2:0]  result_ch_q,    result_ch_d;
    logic [7:0]  result_data_q,  result_data_d;
    logic [63:0] ch_values_q,    ch_values_d;
    logic        host_ack_q,     host_ack_d;
    logic [7:0]  host_data_q,    host_data_d;

    logic        w_scan_found;
    logic [2:0]  w_scan_ch;
    logic [2:0]  w_flush_ch;
    logic [7:0]  w_rx_byte;
    logic        w_unused_rx;

    // Only the 8-bit result field of the received word is meaningful here.
    assign w_rx_byte   = eng.conv_rx[11:4];
    assign w_unused_rx = ^{eng.conv_rx[15:12], eng.conv_rx[3:0]};

    // Next enabled channel strictly after the last scanned one, wrapping 7->0.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_ch    = last_scan_ch_q;
        for (int i = 1; i <= 8; i++) begin
            if (!w_scan_found && chan_en[last_scan_ch_q + 3'(i)]) begin
                w_scan_found = 1'b1;
                w_scan_ch    = last_scan_ch_q + 3'(i);
            end
        end
    end

    // A flush frame with nothing enabled simply re-converts the host channel.
    assign w_flush_ch = w_scan_found ? w_scan_ch : host_ch_q;

    // Next-state logic: tick, host capture, frame selection and result publish.
    always_comb begin
        state_d         = state_q;
        tick_cnt_d      = tick_cnt_q + 16'd1;
        scan_due_d      = scan_due_q;
        host_busy_d     = host_busy_q;
        host_ch_d       = host_ch_q;
        host_issued_d   = host_issued_q;
        last_scan_ch_d  = last_scan_ch_q;
        pending_vld_d   = pending_vld_q;
        pending_ch_d    = pending_ch_q;
        pending_owner_d = pending_owner_q;
        issued_ch_d     = issued_ch_q;
        issued_owner_d  = issued_owner_q;
        conv_start_d    = 1'b0;
        conv_ctrl_d     = conv_ctrl_q;
        result_valid_d  = 1'b0;
        result_ch_d     = result_ch_q;
        result_data_d   = result_data_q;
        ch_values_d     = ch_values_q;
        host_ack_d      = 1'b0;
        host_data_d     = host_data_q;

        // Free-running tick; a tick landing while one is already due is lost.
        if (tick_cnt_q == C_TICK_LAST) begin
            tick_cnt_d = 16'd0;
            scan_due_d = 1'b1;
        end

        // One outstanding host request at a time.
        if (host_req && !host_busy_q) begin
            host_busy_d   = 1'b1;
            host_ch_d     = host_ch;
            host_issued_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_vld_q && (pending_owner_q == OWNER_HOST)) begin
                    // The host result is still inside the ADC; push it out now.
                    issued_ch_d    = w_flush_ch;
                    issued_owner_d = OWNER_SCAN;
                    conv_ctrl_d    = ctrl_word(w_flush_ch);
                    state_d        = ST_ISSUE;
                end else if (host_busy_q && !host_issued_q) begin
                    issued_ch_d    = host_ch_q;
                    issued_owner_d = OWNER_HOST;
                    conv_ctrl_d    = ctrl_word(host_ch_q);
                    host_issued_d  = 1'b1;
                    state_d        = ST_ISSUE;
                end else if (scan_due_q && w_scan_found) begin
                    issued_ch_d    = w_scan_ch;
                    issued_owner_d = OWNER_SCAN;
                    conv_ctrl_d    = ctrl_word(w_scan_ch);
                    last_scan_ch_d = w_scan_ch;
                    scan_due_d     = 1'b0;
                    state_d        = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (!eng.conv_busy) begin
                    conv_start_d = 1'b1;
                    state_d      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (eng.conv_done) begin
                    // The word just received belongs to the previous frame.
                    if (pending_vld_q) begin
                        result_valid_d                          = 1'b1;
                        result_ch_d                             = pending_ch_q;
                        result_data_d                           = w_rx_byte;
                        ch_values_d[{pending_ch_q, 3'b000} +: 8] = w_rx_byte;
                        if (pending_owner_q == OWNER_HOST) begin
                            host_ack_d  = 1'b1;
                            host_data_d = w_rx_byte;
                            host_busy_d = 1'b0;
                        end
                    end
                    pending_vld_d   = 1'b1;
                    pending_ch_d    = issued_ch_q;
                    pending_owner_d = issued_owner_q;
                    state_d         = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops everything, including a frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            tick_cnt_q      <= 16'd0;
            scan_due_q      <= 1'b0;
            host_busy_q     <= 1'b0;
            host_ch_q       <= 3'd0;
            host_issued_q   <= 1'b0;
            last_scan_ch_q  <= 3'd7;
            pending_vld_q   <= 1'b0;
            pending_ch_q    <= 3'd0;
            pending_owner_q <= OWNER_SCAN;
            issued_ch_q     <= 3'd0;
            issued_owner_q  <= OWNER_SCAN;
            conv_start_q    <= 1'b0;
            conv_ctrl_q     <= ctrl_word(3'd0);
            result_valid_q  <= 1'b0;
            result_ch_q     <= 3'd0;
            result_data_q   <= 8'd0;
            ch_values_q     <= 64'd0;
            host_ack_q      <= 1'b0;
            host_data_q     <= 8'd0;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            scan_due_q      <= scan_due_d;
            host_busy_q     <= host_busy_d;
            host_ch_q       <= host_ch_d;
            host_issued_q   <= host_issued_d;
            last_scan_ch_q  <= last_scan_ch_d;
            pending_vld_q   <= pending_vld_d;
            pending_ch_q    <= pending_ch_d;
            pending_owner_q <= pending_owner_d;
            issued_ch_q     <= issued_ch_d;
            issued_owner_q  <= issued_owner_d;
            conv_start_q    <= conv_start_d;
            conv_ctrl_q     <= conv_ctrl_d;
            result_valid_q  <= result_valid_d;
            result_ch_q     <= result_ch_d;
            result_data_q   <= result_data_d;
            ch_values_q     <= ch_values_d;
            host_ack_q      <= host_ack_d;
            host_data_q     <= host_data_d;
        end
    end

    assign eng.conv_start = conv_start_q;
    assign eng.conv_ctrl  = conv_ctrl_q;
    assign host_busy      = host_busy_q;
    assign host_ack       = host_ack_q;
    assign host_data      = host_data_q;
    assign result_valid   = result_valid_q;
    assign result_ch      = result_ch_q;
    assign result_data    = result_data_q;
    assign ch_values      = ch_values_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_scheduler
//  Description : Directed bench for adc_scan_scheduler with a pipelined
//                AD7908 engine model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_scheduler;

    localparam int SCAN_DIV = 40;
    localparam int ENG_LAT  = 20;

    typedef struct { logic [2:0] ch; logic host; } frame_t;
    typedef struct { logic [2:0] ch; logic [7:0] data; logic host; } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  chan_en;
    logic        host_req;
    logic [2:0]  host_ch;
    logic        host_busy;
    logic        host_ack;
    logic [7:0]  host_data;
    logic        result_valid;
    logic [2:0]  result_ch;
    logic [7:0]  result_data;
    logic [63:0] ch_values;

    logic        eng_busy   = 1'b0;
    logic        eng_done   = 1'b0;
    logic [15:0] eng_rx     = 16'd0;
    logic        force_busy = 1'b0;
    logic        stray_done = 1'b0;

    int n_assert  = 0;
    int n_fail    = 0;
    int n_results = 0;
    int n_acks    = 0;

    frame_t exp_frames[$];
    res_t   exp_res[$];

    adc_scan_scheduler_if ifc();

    assign ifc.conv_busy = eng_busy | force_busy;
    assign ifc.conv_done = eng_done | stray_done;
    assign ifc.conv_rx   = eng_rx;

    adc_scan_scheduler #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .chan_en      (chan_en),
        .host_req     (host_req),
        .host_ch      (host_ch),
        .host_busy    (host_busy),
        .host_ack     (host_ack),
        .host_data    (host_data),
        .eng          (ifc),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .result_data  (result_data),
        .ch_values    (ch_values)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_ctrl(input logic [2:0] ch);
        return {3'b101, ch, 10'b11_0111_1111};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_conv_start",   64'(ifc.conv_start), 64'd0);
        chk("rst_conv_ctrl",    64'(ifc.conv_ctrl),  64'h A37F);
        chk("rst_host_busy",    64'(host_busy),      64'd0);
        chk("rst_host_ack",     64'(host_ack),       64'd0);
        chk("rst_host_data",    64'(host_data),      64'd0);
        chk("rst_result_valid", 64'(result_valid),   64'd0);
        chk("rst_result_ch",    64'(result_ch),      64'd0);
        chk("rst_result_data",  64'(result_data),    64'd0);
        chk("rst_ch_values",    ch_values,           64'd0);
    endtask

    task automatic wait_frames(input int bound);
        int t = 0;
        while (exp_frames.size() != 0 && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("frames_issued", 64'(exp_frames.size()), 64'd0);
        exp_frames.delete();
    endtask

    task automatic wait_idle(input int bound);
        int t = 0;
        repeat (2) @(negedge clk);
        while ((eng_busy || exp_res.size() != 0) && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("results_drained", 64'({eng_busy, exp_res.size() != 0}), 64'd0);
        exp_res.delete();
    endtask

    // Engine model: frame N returns 8'h10 + address of frame N-1 in bits [11:4].
    initial begin : engine
        frame_t      cur;
        frame_t      prev;
        logic        prev_vld;
        logic [2:0]  addr;
        logic [2:0]  prev_addr;
        logic [15:0] ctrl_cap;
        logic        stable;
        logic        aborted;
        prev_vld  = 1'b0;
        prev_addr = 3'd0;
        prev      = '{ch: 3'd0, host: 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 1'b0;
            end else if (ifc.conv_start) begin
                ctrl_cap = ifc.conv_ctrl;
                addr     = ctrl_cap[12:10];
                cur      = '{ch: addr, host: 1'b0};
                chk("frame_expected", 64'(exp_frames.size() != 0), 64'd1);
                if (exp_frames.size() != 0) begin
                    cur = exp_frames.pop_front();
                    chk("conv_ctrl", 64'(ctrl_cap), 64'(exp_ctrl(cur.ch)));
                end
                eng_busy = 1'b1;
                stable   = 1'b1;
                aborted  = 1'b0;
                for (int k = 0; k < ENG_LAT; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k == 0) chk("start_single_pulse", 64'(ifc.conv_start), 64'd0);
                    if (ifc.conv_ctrl !== ctrl_cap) stable = 1'b0;
                end
                if (aborted) begin
                    eng_busy = 1'b0;
                    prev_vld = 1'b0;
                end else begin
                    chk("ctrl_stable", 64'(stable), 64'd1);
                    eng_rx = {4'hC, 8'h10 + 8'(prev_addr), 4'h3};
                    if (prev_vld)
                        exp_res.push_back('{ch: prev.ch, data: 8'h10 + 8'(prev.ch), host: prev.host});
                    eng_done = 1'b1;
                    @(negedge clk);
                    eng_done  = 1'b0;
                    eng_busy  = 1'b0;
                    prev      = cur;
                    prev_vld  = 1'b1;
                    prev_addr = addr;
                end
            end
        end
    end

    // Result monitor: every result pulse must match the scoreboard head.
    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (host_ack) begin
                    n_acks++;
                    chk("ack_with_result", 64'(result_valid), 64'd1);
                end
                if (result_valid) begin
                    n_results++;
                    chk("result_expected", 64'(exp_res.size() != 0), 64'd1);
                    if (exp_res.size() != 0) begin
                        r = exp_res.pop_front();
                        chk("result_ch",   64'(result_ch),   64'(r.ch));
                        chk("result_data", 64'(result_data), 64'(r.data));
                        chk("bank_byte",   64'(ch_values[{r.ch, 3'b000} +: 8]), 64'(r.data));
                        chk("host_ack",    64'(host_ack),    64'(r.host));
                        if (r.host) chk("host_data", 64'(host_data), 64'(r.data));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n_start_hold;
        int res_before;
        rst      = 1'b1;
        chan_en  = 8'h00;
        host_req = 1'b0;
        host_ch  = 3'd0;
        repeat (3) @(negedge clk);
        chk_reset_values();
        rst = 1'b0;

        // Round robin over ch0/ch1; first frame is discarded.
        exp_frames.push_back('{ch: 3'd0, host: 1'b0});
        exp_frames.push_back('{ch: 3'd1, host: 1'b0});
        exp_frames.push_back('{ch: 3'd0, host: 1'b0});
        exp_frames.push_back('{ch: 3'd1, host: 1'b0});
        chan_en = 8'h03;
        wait_frames(8 * SCAN_DIV);
        chan_en = 8'h00;
        wait_idle(100);
        chk("bank_ch01", 64'(ch_values[15:0]), 64'h1110);

        // Nothing enabled: no frames for three tick periods, then ch7 only.
        repeat (3 * SCAN_DIV) @(negedge clk);
        exp_frames.push_back('{ch: 3'd7, host: 1'b0});
        chan_en = 8'h80;
        wait_frames(2 * SCAN_DIV);
        chan_en = 8'h00;
        wait_idle(100);

        // Host request on ch5 with scan idle: host frame then flush frame.
        exp_frames.push_back('{ch: 3'd5, host: 1'b1});
        exp_frames.push_back('{ch: 3'd5, host: 1'b0});
        host_req = 1'b1;
        host_ch  = 3'd5;
        @(negedge clk);
        host_req = 1'b0;
        chk("host_busy_set", 64'(host_busy), 64'd1);
        repeat (3) @(negedge clk);
        host_req = 1'b1;
        host_ch  = 3'd2;
        @(negedge clk);
        host_req = 1'b0;
        wait_frames(200);
        wait_idle(100);
        chk("host_ack_count", 64'(n_acks), 64'd1);
        chk("host_busy_clr",  64'(host_busy), 64'd0);
        chk("host_data_held", 64'(host_data), 64'h15);

        // Host request while a scan is due: host, flush, then one scan frame.
        repeat (2 * SCAN_DIV) @(negedge clk);
        exp_frames.push_back('{ch: 3'd3, host: 1'b1});
        exp_frames.push_back('{ch: 3'd0, host: 1'b0});
        exp_frames.push_back('{ch: 3'd0, host: 1'b0});
        host_req = 1'b1;
        host_ch  = 3'd3;
        @(negedge clk);
        host_req = 1'b0;
        chan_en  = 8'h03;
        wait_frames(300);
        chan_en = 8'h00;
        wait_idle(100);
        chk("host_ack_count2", 64'(n_acks), 64'd2);
        chk("host_data2",      64'(host_data), 64'h13);

        // Engine busy holds the frame in ISSUE; chan_en changes after selection.
        repeat (2 * SCAN_DIV) @(negedge clk);
        force_busy = 1'b1;
        exp_frames.push_back('{ch: 3'd1, host: 1'b0});
        chan_en = 8'h02;
        @(negedge clk);
        chan_en = 8'h00;
        n_start_hold = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifc.conv_start) n_start_hold++;
        end
        chk("start_withheld", 64'(n_start_hold), 64'd0);
        force_busy = 1'b0;
        wait_frames(20);
        wait_idle(100);

        // Reset while waiting for conv_done, then a stray conv_done.
        exp_frames.push_back('{ch: 3'd0, host: 1'b0});
        chan_en = 8'h01;
        wait_frames(2 * SCAN_DIV);
        chan_en = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_values();
        exp_res.delete();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values();
        res_before = n_results;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("stray_done_ignored", 64'(n_results - res_before), 64'd0);
        chk("stray_bank",         ch_values, 64'd0);

        // After reset the first frame is discarded again.
        exp_frames.push_back('{ch: 3'd0, host: 1'b0});
        exp_frames.push_back('{ch: 3'd0, host: 1'b0});
        chan_en = 8'h01;
        wait_frames(4 * SCAN_DIV);
        chan_en = 8'h00;
        wait_idle(100);
        chk("post_rst_results", 64'(n_results - res_before), 64'd1);
        chk("post_rst_bank",    ch_values, 64'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Sequences the 16-bit AD7908 SPI frame engine. Round-robins conversions over enabled channels on a periodic tick, and gives one-shot host requests priority. Compensates for the ADC's one-frame result pipeline, where frame N returns the conversion addressed in frame N-1. It sits between the frame engine (start/busy/done handshake) and consumers: a per-channel value bank plus a result stream.

Parameters:
SCAN_DIV, 50000, clk cycles between scan ticks (1 kHz at 50 MHz); legal range 2..65535.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
chan_en  in  8  scan enable mask, bit i = channel i
host_req  in  1  one-cycle host conversion request
host_ch  in  3  channel for host_req, sampled with it
host_busy  out  1  host request accepted and not yet acknowledged
host_ack  out  1  one-cycle pulse, host result ready
host_data  out  8  host result, valid with host_ack, held after
conv_start  out  1  one-cycle frame start to engine
conv_ctrl  out  16  control word, stable from conv_start until conv_done
conv_busy  in  1  engine busy
conv_done  in  1  one-cycle frame complete
conv_rx  in  16  received word, valid with conv_done
result_valid  out  1  one-cycle pulse, new result
result_ch  out  3  channel of result
result_data  out  8  result value = conv_rx[11:4]
ch_values  out  64  value bank, byte i = last result of channel i

Behaviour:
- Reset values:
  - outputs: all 0; conv_ctrl = ctrl word for channel 0.
  - internal: state IDLE, pending_vld=0, scan_due=0, tick counter 0, last_scan_ch=7.
- Control word: {1,0,1,ADD[2:0],1,1,0,1,1,1,4'b1111}.
  - This encodes WRITE, SEQ=0, normal power (PM=11), SHADOW=0, RANGE=1, CODING=1.
- Tick counter:
  - Counts 0..SCAN_DIV-1 continuously; at wrap sets scan_due.
  - scan_due is sticky, cleared when a scan frame issues. Ticks arriving while scan_due=1 are dropped, not queued.
- Host request:
  - Accepted when host_req=1 and host_busy=0; latches host_ch and sets host_busy.
  - host_req while host_busy=1 is ignored.
- FSM states:
  - IDLE: pick the next frame in this priority order:
    1. flush frame: pending_vld and pending_owner=HOST → issue at once, channel = next scan channel (host_ch if chan_en=0), owner SCAN, does not clear scan_due.
    2. host frame: host_busy and not yet issued → channel host_ch, owner HOST.
    3. scan frame: scan_due and chan_en≠0 → next enabled channel after last_scan_ch, wrapping 7→0. Update last_scan_ch and clear scan_due.
    4. otherwise stay in IDLE.
  - ISSUE: hold conv_ctrl; when conv_busy=0, pulse conv_start one cycle, go to WAIT.
  - WAIT: on conv_done:
    - if pending_vld, publish on the next cycle: result_valid pulse, result_ch=pending_ch, result_data=conv_rx[11:4], ch_values byte updated.
    - if pending_owner=HOST, also host_ack pulse, host_data=same value, host_busy cleared.
    - Then pending ← {1, issued channel, issued owner}; return to IDLE.
- Ignored inputs: conv_done outside WAIT is ignored; conv_rx bits other than [11:4] are ignored.
- Latency:
  - conv_done → result_valid/host_ack: 1 cycle.
  - IDLE → conv_start: 2 cycles minimum when conv_busy=0.
- First frame after reset has pending_vld=0; its data is discarded, with no result_valid.
- chan_en is sampled at channel selection only. Changing it mid-frame does not affect the frame in flight.
- Reset mid-frame: everything returns to reset values immediately and conv_start is forced low. A late conv_done from the engine is ignored (state IDLE).

Test Plan:
- Reset, chan_en=8'h03, engine model returns conv_rx[11:4]=8'h10+addr_of_previous_frame → frame channels 0,1,0,1…; first frame gives no result_valid; later results ch0=8'h10, ch1=8'h11; ch_values[15:0]=16'h1110.
- chan_en=8'h00 for 3 tick periods → no conv_start. Then chan_en=8'h80 → next frame addresses ch7 (conv_ctrl[12:10]=3'b111).
- host_req with host_ch=5 while scan idle → host frame (ch5) then immediate flush frame. host_ack exactly once, host_data=value for ch5, host_busy low after ack; second host_req during busy ignored.
- host_req coincident with scan_due → host frame issues first, flush next, scan frame after. Both scan_due ticks (during host op) yield only one scan frame.
- Hold conv_busy=1 for 100 cycles while in ISSUE → conv_start is withheld until conv_busy=0, then a single pulse with conv_ctrl stable until conv_done.
- Assert rst in WAIT, release, then send a stray conv_done → no result_valid, outputs at reset values, next frame is again discarded.
